fill_engine: RTL and testbench

FILL_ENGINE -- requirements
Module: fill_engine

---
 rtl/fill_engine.sv | 140 ++++++++++++++
 tb/tb_fill_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fill_engine.sv
// fill_engine: fills a frame buffer with one RGB colour via a ready/valid
// write port.
// Optional build macro: FILL_CHECKER_EN alternates colour and its complement
// in an 8x8 checkerboard.
module fill_engine #(
  parameter int          H_RES = 800,
  parameter int          V_RES = 600,
  parameter logic [31:0] BASE0 = 32'h1080_0000,
  parameter logic [31:0] BASE1 = 32'h1040_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        start_ack,
  output logic        done,
  input  logic        done_ack,
  input  logic        frame_sel,
  input  logic [23:0] color,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;

`ifdef FILL_CHECKER_EN
  logic [23:0]   color_q, color_d;

  // Pixel word for a coordinate: bit 3 of x and y selects colour or complement.
  function automatic logic [31:0] pixel(input logic [XW-1:0] px,
                                        input logic [YW-1:0] py,
                                        input logic [23:0]   col);
    logic [31:0] xe;
    logic [31:0] ye;
    xe = 32'(px);
    ye = 32'(py);
    return (xe[3] ^ ye[3]) ? {8'h00, ~col} : {8'h00, col};
  endfunction
`endif

  // Next-state, counter/address stepping and handshake outputs.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    data_d    = data_q;
`ifdef FILL_CHECKER_EN
    color_d   = color_q;
`endif
    start_ack = 1'b0;
    done      = 1'b0;
    wr_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_ack && !reset) begin
          start_ack = 1'b1;
          x_d       = '0;
          y_d       = '0;
          addr_d    = frame_sel ? BASE1 : BASE0;
          data_d    = {8'h00, color};
`ifdef FILL_CHECKER_EN
          color_d   = color;
`endif
          state_d   = FILL;
        end
      end
      FILL: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          addr_d = addr_q + 32'd4;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              state_d = DONE;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
`ifdef FILL_CHECKER_EN
          data_d = pixel(x_d, y_d, color_q);
`endif
        end
      end
      DONE: begin
        done = 1'b1;
        if (done_ack) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!done_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, coordinate and write-word registers; reset abandons any fill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef FILL_CHECKER_EN
      color_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef FILL_CHECKER_EN
      color_q <= color_d;
`endif
    end
  end

  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule

// File: tb/tb_fill_engine.sv
// tb_fill_engine: directed bench for fill_engine on a 4x2 frame.
module tb_fill_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        start_ack;
  logic        done;
  logic        done_ack;
  logic        frame_sel;
  logic [23:0] color;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;

  fill_engine #(
    .H_RES(4), .V_RES(2), .BASE0(32'h100), .BASE1(32'h200)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .start_ack(start_ack),
    .done(done), .done_ack(done_ack), .frame_sel(frame_sel), .color(color),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

`ifdef FILL_CHECKER_EN
  logic        start_c;
  logic        done_ack_c;
  logic        c_start_ack;
  logic        c_done;
  logic        c_wr_valid;
  logic [31:0] c_wr_addr;
  logic [31:0] c_wr_data;

  fill_engine #(
    .H_RES(16), .V_RES(1), .BASE0(32'h100), .BASE1(32'h200)
  ) dut_chk (
    .clock(clock), .reset(reset), .start(start_c), .start_ack(c_start_ack),
    .done(c_done), .done_ack(done_ack_c), .frame_sel(frame_sel), .color(color),
    .wr_valid(c_wr_valid), .wr_ready(wr_ready), .wr_addr(c_wr_addr),
    .wr_data(c_wr_data)
  );
`endif

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic fsel, input logic [23:0] col);
    start     = 1'b1;
    frame_sel = fsel;
    color     = col;
    done_ack  = 1'b0;
    #1;
    check("start_ack_pulse", {31'b0, start_ack}, 32'd1);
    tick;
    start = 1'b0;
    check("start_ack_drop", {31'b0, start_ack}, 32'd0);
  endtask

  // Runs one 8-word fill, checking every address/data and stall holding.
  task automatic fill(input logic [31:0] base, input logic [31:0] exp_data,
                      input bit toggle, input bit change_mid);
    int          n;
    int          cyc;
    bit          stalled;
    logic [31:0] pa;
    logic [31:0] pd;
    n = 0;
    cyc = 0;
    stalled = 0;
    pa = '0;
    pd = '0;
    while (n < 8 && cyc < 64) begin
      wr_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      check("fill_valid", {31'b0, wr_valid}, 32'd1);
      if (stalled) begin
        check("stall_addr_hold", wr_addr, pa);
        check("stall_data_hold", wr_data, pd);
      end
      if (wr_ready) begin
        check("fill_addr", wr_addr, base + 32'(4 * n));
        check("fill_data", wr_data, exp_data);
        n++;
      end
      stalled = !wr_ready;
      pa = wr_addr;
      pd = wr_data;
      if (change_mid && n == 3) begin
        color     = 24'h00FF00;
        frame_sel = 1'b0;
      end
      tick;
      cyc++;
    end
    check("fill_count", 32'(n), 32'd8);
    wr_ready = 1'b1;
    check("valid_after_fill", {31'b0, wr_valid}, 32'd0);
    check("done_after_fill", {31'b0, done}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b1;
    done_ack  = 1'b0;
    frame_sel = 1'b0;
    color     = 24'h123456;
    wr_ready  = 1'b1;
`ifdef FILL_CHECKER_EN
    start_c    = 1'b0;
    done_ack_c = 1'b0;
`endif
    #1;
    check("rst_start_ack", {31'b0, start_ack}, 32'd0);
    check("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    tick;
    tick;
    reset = 1'b0;

    $display("[TB] start blocked while done_ack high");
    done_ack = 1'b1;
    #1;
    check("no_ack_done_ack_hi", {31'b0, start_ack}, 32'd0);
    tick;
    check("idle_no_valid", {31'b0, wr_valid}, 32'd0);
    check("idle_no_ack", {31'b0, start_ack}, 32'd0);

    $display("[TB] basic fill, buffer 0");
    do_start(1'b0, 24'h123456);
    fill(32'h100, 32'h0012_3456, 1'b0, 1'b0);

    $display("[TB] four-phase completion with start held");
    frame_sel = 1'b1;
    color     = 24'h0F0F0F;
    start     = 1'b1;
    #1;
    check("no_ack_in_done", {31'b0, start_ack}, 32'd0);
    tick;
    tick;
    check("done_held", {31'b0, done}, 32'd1);
    done_ack = 1'b1;
    #1;
    check("done_before_sample", {31'b0, done}, 32'd1);
    tick;
    check("done_fell", {31'b0, done}, 32'd0);
    check("no_ack_release", {31'b0, start_ack}, 32'd0);
    tick;
    check("release_done_low", {31'b0, done}, 32'd0);
    tick;
    done_ack = 1'b0;
    #1;
    check("no_ack_still_release", {31'b0, start_ack}, 32'd0);
    tick;
    check("ack_back_in_idle", {31'b0, start_ack}, 32'd1);
    tick;
    start = 1'b0;

    $display("[TB] buffer 1 with stalls and mid-fill input changes");
    fill(32'h200, 32'h000F_0F0F, 1'b1, 1'b1);
    done_ack = 1'b1;
    tick;
    check("done_fell_2", {31'b0, done}, 32'd0);
    done_ack = 1'b0;
    tick;

    $display("[TB] reset during fill");
    do_start(1'b0, 24'h00AA55);
    wr_ready = 1'b1;
    tick;
    tick;
    tick;
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'b0, wr_valid}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_addr", wr_addr, 32'd0);
    tick;
    reset = 1'b0;
    tick;
    check("post_rst_idle", {31'b0, wr_valid}, 32'd0);
    tick;
    check("post_rst_idle2", {31'b0, wr_valid}, 32'd0);
    do_start(1'b0, 24'h00AA55);
    fill(32'h100, 32'h0000_AA55, 1'b0, 1'b0);

`ifdef FILL_CHECKER_EN
    $display("[TB] checkerboard fill");
    start_c   = 1'b1;
    frame_sel = 1'b0;
    color     = 24'hFF0000;
    wr_ready  = 1'b1;
    #1;
    check("chk_start_ack", {31'b0, c_start_ack}, 32'd1);
    tick;
    start_c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("chk_valid", {31'b0, c_wr_valid}, 32'd1);
      check("chk_addr", c_wr_addr, 32'h100 + 32'(4 * i));
      check("chk_data", c_wr_data, (i < 8) ? 32'h00FF_0000 : 32'h0000_FFFF);
      tick;
    end
    check("chk_done", {31'b0, c_done}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
